// File: rtl/mul_pkg.sv
// Shared encodings, FSM state type and operand-signedness decode for the iterative multiplier.
package mul_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } mul_state_t;

    typedef struct packed {
        logic rs1_signed;
        logic rs2_signed;
    } sign_sel_t;

    function automatic sign_sel_t operand_signs(input logic [2:0] funct3);
        sign_sel_t s;
        s.rs1_signed = (funct3 == FUNCT3_MUL) || (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU);
        s.rs2_signed = (funct3 == FUNCT3_MUL) || (funct3 == FUNCT3_MULH);
        return s;
    endfunction

endpackage

// File: rtl/iterative_multiplier_unit_if.sv
// Execute-stage request/response bundle between the core and the multiply unit.
interface iterative_multiplier_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic            flush;
    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] mul_output;

    modport master (
        output start, flush, opcode, funct7, funct3, rs1, rs2,
        input  busy, valid, mul_output
    );

    modport slave (
        input  start, flush, opcode, funct7, funct3, rs1, rs2,
        output busy, valid, mul_output
    );
endinterface

// File: rtl/mul_radix_step.sv
// One shift-add iteration: accumulate multiplicand * digit, aligned to the digit's bit position.
module mul_radix_step #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 4,
    parameter int unsigned SHW            = $clog2(2 * XLEN)
) (
    input  logic [2*XLEN-1:0]         i_acc,
    input  logic [XLEN-1:0]           i_mcand,
    input  logic [BITS_PER_CYCLE-1:0] i_digit,
    input  logic [SHW-1:0]            i_shift,
    output logic [2*XLEN-1:0]         o_acc
);
    localparam int unsigned PW = XLEN + BITS_PER_CYCLE;
    localparam int unsigned AW = 2 * XLEN;

    logic [PW-1:0] w_partial;
    logic [AW-1:0] w_aligned;

    assign w_partial = PW'(i_mcand) * PW'(i_digit);
    assign w_aligned = AW'(w_partial) << i_shift;
    assign o_acc     = i_acc + w_aligned;
endmodule

// File: rtl/iterative_multiplier_unit.sv
// Multi-cycle RV32M/RV64M MUL/MULH/MULHSU/MULHU unit: magnitude shift-add, then sign fix and half select.
module iterative_multiplier_unit
    import mul_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 4,
    parameter bit          EARLY_ZERO     = 1'b1
) (
    input logic                         CLK,
    input logic                         reset_n,
    iterative_multiplier_unit_if.slave  bus
);
    localparam int unsigned N   = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SHW = $clog2(2 * XLEN);

    if ((XLEN != 32 && XLEN != 64) || (XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_params
        $error("iterative_multiplier_unit: XLEN must be 32/64 and divisible by BITS_PER_CYCLE");
    end

    mul_state_t        r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_mcand, r_mplier, r_out;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg, r_high, r_valid;

    sign_sel_t         w_signs;
    logic              w_neg1, w_neg2, w_zero, w_accept, w_last;
    logic [XLEN-1:0]   w_mag1, w_mag2;
    logic [2*XLEN-1:0] w_acc_next, w_prod;
    logic [SHW-1:0]    w_shift;

    assign w_signs  = operand_signs(bus.funct3);
    assign w_neg1   = w_signs.rs1_signed & bus.rs1[XLEN-1];
    assign w_neg2   = w_signs.rs2_signed & bus.rs2[XLEN-1];
    assign w_mag1   = w_neg1 ? -bus.rs1 : bus.rs1;
    assign w_mag2   = w_neg2 ? -bus.rs2 : bus.rs2;
    assign w_zero   = (bus.rs1 == '0) || (bus.rs2 == '0);
    assign w_accept = bus.start && !bus.flush && (r_state == IDLE)
                   && (bus.opcode == OPCODE_OP) && (bus.funct7 == FUNCT7_MULDIV)
                   && (bus.funct3[2] == 1'b0);
    assign w_last   = (r_cnt == CW'(N - 1));
    assign w_shift  = SHW'(r_cnt) * SHW'(BITS_PER_CYCLE);
    assign w_prod   = r_neg ? -r_acc : r_acc;

    // Multiplier is consumed LSB-first; r_mplier is shifted so its low digit is always current.
    mul_radix_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .SHW            (SHW)
    ) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_digit (r_mplier[BITS_PER_CYCLE-1:0]),
        .i_shift (w_shift),
        .o_acc   (w_acc_next)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = (EARLY_ZERO && w_zero) ? FIX : CALC;
            CALC: begin
                if (bus.flush)   w_next = IDLE;
                else if (w_last) w_next = FIX;
            end
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_high   <= 1'b0;
            r_out    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                IDLE: if (w_accept) begin
                    r_mcand  <= w_mag1;
                    r_mplier <= w_mag2;
                    r_neg    <= w_neg1 ^ w_neg2;
                    r_high   <= (bus.funct3 != FUNCT3_MUL);
                    r_cnt    <= '0;
                    r_acc    <= '0;
                end
                CALC: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt    <= r_cnt + CW'(1);
                end
                FIX: if (!bus.flush) begin
                    r_out   <= r_high ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // busy covers the iteration phase only, so the zero fast path never raises it.
    assign bus.busy       = (r_state == CALC);
    assign bus.valid      = r_valid;
    assign bus.mul_output = r_out;
endmodule

// File: tb/tb_iterative_multiplier_unit.sv
// Directed bench for iterative_multiplier_unit with a queue scoreboard and independent valid monitor.
module tb_iterative_multiplier_unit;
    import mul_pkg::*;

    logic CLK;
    logic reset_n;

    iterative_multiplier_unit_if #(.XLEN(32)) bus ();

    iterative_multiplier_unit #(
        .XLEN           (32),
        .BITS_PER_CYCLE (4),
        .EARLY_ZERO     (1'b1)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_res = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (bus.valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: got valid=1 mul_output=0x%08h, required valid=0", bus.mul_output);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check({e.nm, " result"}, bus.mul_output, e.val);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        bus.opcode = OPCODE_OP;
        bus.funct7 = f7;
        bus.funct3 = f3;
        bus.rs1    = a;
        bus.rs2    = b;
        bus.start  = 1'b1;
    endtask

    // Issue one operation, expect its result, and measure accept-to-valid edges and busy cycles.
    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input int exp_busy, input bit hold);
        int edges;
        int busy_cnt;
        exp_t e;
        drive(f3, FUNCT7_MULDIV, a, b);
        e.nm = nm;
        e.val = exp_res;
        q.push_back(e);
        last_res = exp_res;
        @(posedge CLK);
        #1;
        if (hold) begin
            bus.rs1    = 32'hDEADBEEF;
            bus.rs2    = 32'h00000003;
            bus.funct3 = FUNCT3_MULHU;
        end else begin
            bus.start = 1'b0;
        end
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
        edges = 0;
        while (bus.valid !== 1'b1 && edges < 40) begin
            if (hold && bus.busy !== 1'b1) bus.start = 1'b0;
            @(posedge CLK);
            edges++;
            #1;
            if (bus.valid !== 1'b1 && bus.busy === 1'b1) busy_cnt++;
        end
        bus.start = 1'b0;
        check({nm, " latency"}, 32'(edges), 32'(exp_lat));
        check({nm, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int n;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.opcode = '0;
        bus.funct7 = '0;
        bus.funct3 = '0;
        bus.rs1    = '0;
        bus.rs2    = '0;
        idle_cycles(2);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset valid", 32'(bus.valid), 32'd0);
        check("reset mul_output", bus.mul_output, 32'h0);
        reset_n = 1'b1;
        idle_cycles(1);

        run_op("MUL 6*7", FUNCT3_MUL, 32'd6, 32'd7, 32'h0000002A, 9, 8, 1'b0);
        run_op("MULH min*min", FUNCT3_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 9, 8, 1'b0);
        run_op("MULH -1*-1", FUNCT3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 9, 8, 1'b0);
        run_op("MULHSU -1*max", FUNCT3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 9, 8, 1'b0);
        run_op("MUL -3*5", FUNCT3_MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 9, 8, 1'b0);
        run_op("MULH -2*3", FUNCT3_MULH, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 9, 8, 1'b0);
        run_op("MULHU hex*16", FUNCT3_MULHU, 32'h12345678, 32'h10, 32'h00000001, 9, 8, 1'b0);
        run_op("MUL hold+restart", FUNCT3_MUL, 32'h12345678, 32'h10, 32'h23456780, 9, 8, 1'b1);
        run_op("MULHU max*max", FUNCT3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 9, 8, 1'b0);

        // Flush three cycles into an operation: no result, output retained.
        drive(FUNCT3_MUL, FUNCT7_MULDIV, 32'd3, 32'd4);
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        idle_cycles(2);
        bus.flush = 1'b1;
        idle_cycles(1);
        bus.flush = 1'b0;
        check("flush busy", 32'(bus.busy), 32'd0);
        idle_cycles(12);
        check("flush keeps output", bus.mul_output, last_res);

        // Flush in the final (sign-fix) cycle suppresses the result.
        drive(FUNCT3_MUL, FUNCT7_MULDIV, 32'd5, 32'd5);
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            idle_cycles(1);
            n++;
        end
        bus.flush = 1'b1;
        idle_cycles(1);
        bus.flush = 1'b0;
        check("fix flush valid", 32'(bus.valid), 32'd0);
        idle_cycles(3);
        check("fix flush keeps output", bus.mul_output, last_res);

        // start with flush in the same cycle is not accepted.
        drive(FUNCT3_MUL, FUNCT7_MULDIV, 32'd2, 32'd2);
        bus.flush = 1'b1;
        idle_cycles(1);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start+flush busy", 32'(bus.busy), 32'd0);
        idle_cycles(12);

        // Non-M funct7 is ignored.
        drive(FUNCT3_MUL, 7'b0000000, 32'd2, 32'd2);
        idle_cycles(1);
        bus.start = 1'b0;
        check("bad funct7 busy", 32'(bus.busy), 32'd0);
        idle_cycles(12);

        run_op("MUL zero fast", FUNCT3_MUL, 32'h0, 32'h12345678, 32'h00000000, 1, 0, 1'b0);
        run_op("MULHU zero fast", FUNCT3_MULHU, 32'hFFFFFFFF, 32'h0, 32'h00000000, 1, 0, 1'b0);
        run_op("MUL 9*9", FUNCT3_MUL, 32'd9, 32'd9, 32'h00000051, 9, 8, 1'b0);

        // Asynchronous reset mid-iteration clears outputs at once.
        drive(FUNCT3_MUL, FUNCT7_MULDIV, 32'd11, 32'd13);
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
        idle_cycles(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset busy", 32'(bus.busy), 32'd0);
        check("async reset valid", 32'(bus.valid), 32'd0);
        check("async reset mul_output", bus.mul_output, 32'h0);
        last_res = '0;
        idle_cycles(2);
        reset_n = 1'b1;
        idle_cycles(1);

        run_op("MUL 6*7 after reset", FUNCT3_MUL, 32'd6, 32'd7, 32'h0000002A, 9, 8, 1'b0);

        idle_cycles(3);
        check("scoreboard drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
